// File: rtl/cart_pkg.sv
// Shared types and helpers for the cartridge loader: state encoding, default
// RAM geometry and the power-of-two mirror-mask function.
package cart_pkg;

    localparam int CART_ADDR_W = 14;
    localparam int CART_BYTES  = 2**CART_ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FINISH,
        ST_FILL,
        ST_HOLD,
        ST_RUN
    } cart_state_t;

    // Bit i of the mask is set when 2^i < size, i.e. mask = next_pow2(size) - 1.
    function automatic logic [31:0] pow2_mask(input logic [31:0] size, input int aw);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < size) begin
                m = m | (32'd1 << i);
            end
        end
        if (aw < 32) begin
            m = m & ((32'd1 << aw) - 32'd1);
        end
        return m;
    endfunction

endpackage

// File: rtl/cart_read_pipe.sv
// Two-stage cpu_req -> cpu_ack delay line; data is forced to 8'hFF whenever
// the RAM was not (or is no longer) serving CPU reads.
module cart_read_pipe
    import cart_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_req,
    input  logic       ram_ok,
    input  logic [7:0] mem_rdata,
    output logic       cpu_ack,
    output logic [7:0] cpu_data
);

    logic req_d1_reg;
    logic ok_d1_reg;
    logic ack_reg;
    logic sel_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_d1_reg <= 1'b0;
            ok_d1_reg  <= 1'b0;
            ack_reg    <= 1'b0;
            sel_reg    <= 1'b0;
        end else begin
            req_d1_reg <= cpu_req;
            ok_d1_reg  <= cpu_req & ram_ok;
            ack_reg    <= req_d1_reg;
            sel_reg    <= req_d1_reg & ok_d1_reg & ram_ok;
        end
    end

    // RAM data arrives in the ack cycle; a download starting meanwhile drops ram_ok.
    assign cpu_ack  = ack_reg;
    assign cpu_data = (sel_reg && ram_ok) ? mem_rdata : 8'hFF;

endmodule

// File: rtl/cart_load_ctrl.sv
// Cartridge image loader and RAM arbiter between the ioctl writer and CPU reads.
// Define CART_FILL_EN to pad the image with 8'hFF up to the mirror boundary.
module cart_load_ctrl
    import cart_pkg::*;
#(
    parameter int         ADDR_W      = CART_ADDR_W,
    parameter logic [7:0] CART_INDEX  = 8'd1,
    parameter int         HOLD_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [15:0]       ioctl_addr,
    input  logic [7:0]        ioctl_data,
    input  logic [7:0]        ioctl_index,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [7:0]        cpu_data,
    output logic              cpu_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    input  logic [7:0]        mem_rdata,
    output logic              cart_present,
    output logic [ADDR_W-1:0] cart_mask,
    output logic              overflow,
    output logic              hold_reset
);

    localparam logic [ADDR_W:0]   BYTES     = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   SIZE_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam int                HCW       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HCW-1:0]    HOLD_LAST = HCW'(HOLD_CYCLES - 1);

    cart_state_t       state_reg;
    logic              dl_prev_reg;
    logic [ADDR_W:0]   size_reg;
    logic [ADDR_W-1:0] cart_mask_reg;
    logic              cart_present_reg;
    logic              overflow_reg;
    logic              hold_reset_reg;
    logic [HCW-1:0]    hold_cnt_reg;
    logic [ADDR_W-1:0] rd_addr_reg;
`ifdef CART_FILL_EN
    logic [ADDR_W-1:0] fill_addr_reg;
    logic [ADDR_W-1:0] fill_end;
`endif

    logic              dl_rise;
    logic              dl_fall;
    logic              cart_start;
    logic              wr_in_range;
    logic              load_wr;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W:0]   wr_size;
    logic [ADDR_W-1:0] fin_mask;
    logic              ram_ok;

    assign dl_rise     = ioctl_download & ~dl_prev_reg;
    assign dl_fall     = ~ioctl_download & dl_prev_reg;
    assign cart_start  = dl_rise && (ioctl_index == CART_INDEX);
    assign wr_in_range = ({1'b0, ioctl_addr} < 17'(BYTES));
    assign load_wr     = (state_reg == ST_LOAD) && ioctl_wr && wr_in_range;
    assign wr_addr     = ioctl_addr[ADDR_W-1:0];
    assign wr_size     = {1'b0, wr_addr} + SIZE_ONE;
    assign fin_mask    = ADDR_W'(pow2_mask(32'(size_reg), ADDR_W));
    assign ram_ok      = (state_reg == ST_RUN) && cart_present_reg;
`ifdef CART_FILL_EN
    // An empty image pads the whole RAM rather than just address 0.
    assign fill_end    = (size_reg == '0) ? {ADDR_W{1'b1}} : cart_mask_reg;
`endif

    // Writer owns the RAM outside RUN; CPU reads use the latched address.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = rd_addr_reg;
        mem_wdata = 8'h00;
        if (load_wr) begin
            mem_we    = 1'b1;
            mem_addr  = wr_addr;
            mem_wdata = ioctl_data;
        end
`ifdef CART_FILL_EN
        else if (state_reg == ST_FILL) begin
            mem_we    = 1'b1;
            mem_addr  = fill_addr_reg;
            mem_wdata = 8'hFF;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            dl_prev_reg      <= 1'b0;
            size_reg         <= '0;
            cart_mask_reg    <= '0;
            cart_present_reg <= 1'b0;
            overflow_reg     <= 1'b0;
            hold_reset_reg   <= 1'b1;
            hold_cnt_reg     <= '0;
            rd_addr_reg      <= '0;
`ifdef CART_FILL_EN
            fill_addr_reg    <= '0;
`endif
        end else begin
            dl_prev_reg <= ioctl_download;
            if (cart_start) begin
                state_reg        <= ST_LOAD;
                cart_present_reg <= 1'b0;
                overflow_reg     <= 1'b0;
                size_reg         <= '0;
                hold_reset_reg   <= 1'b1;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        state_reg    <= ST_HOLD;
                        hold_cnt_reg <= '0;
                    end
                    ST_LOAD: begin
                        if (ioctl_wr) begin
                            if (!wr_in_range) begin
                                overflow_reg <= 1'b1;
                            end else if (wr_size > size_reg) begin
                                size_reg <= wr_size;
                            end
                        end
                        if (dl_fall) begin
                            state_reg <= ST_FINISH;
                        end
                    end
                    ST_FINISH: begin
                        cart_mask_reg    <= fin_mask;
                        cart_present_reg <= (size_reg != '0);
                        hold_cnt_reg     <= '0;
`ifdef CART_FILL_EN
                        if ((size_reg == '0) || (size_reg <= {1'b0, fin_mask})) begin
                            state_reg     <= ST_FILL;
                            fill_addr_reg <= size_reg[ADDR_W-1:0];
                        end else begin
                            state_reg <= ST_HOLD;
                        end
`else
                        state_reg <= ST_HOLD;
`endif
                    end
`ifdef CART_FILL_EN
                    ST_FILL: begin
                        if (fill_addr_reg == fill_end) begin
                            state_reg <= ST_HOLD;
                        end else begin
                            fill_addr_reg <= fill_addr_reg + ADDR_W'(1);
                        end
                    end
`endif
                    ST_HOLD: begin
                        if (hold_cnt_reg == HOLD_LAST) begin
                            state_reg      <= ST_RUN;
                            hold_reset_reg <= 1'b0;
                        end else begin
                            hold_cnt_reg <= hold_cnt_reg + HCW'(1);
                        end
                    end
                    ST_RUN: begin
                        if (cpu_req) begin
                            rd_addr_reg <= cpu_addr & cart_mask_reg;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    cart_read_pipe u_read_pipe (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .ram_ok    (ram_ok),
        .mem_rdata (mem_rdata),
        .cpu_ack   (cpu_ack),
        .cpu_data  (cpu_data)
    );

    assign cart_present = cart_present_reg;
    assign cart_mask    = cart_mask_reg;
    assign overflow     = overflow_reg;
    assign hold_reset   = hold_reset_reg;

endmodule

// File: tb/tb_cart_load_ctrl.sv
// Directed bench for cart_load_ctrl with a behavioural image/mask model and a
// registered RAM. Build with CART_FILL_EN defined to cover the padding feature.
module tb_cart_load_ctrl;

    localparam int         BYTES    = 16384;
    localparam int         HOLD     = 1024;
    localparam logic [7:0] CART_IDX = 8'd1;

    logic        clk = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [15:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic [7:0]  ioctl_index;
    logic        cpu_req;
    logic [13:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        cpu_ack;
    logic [13:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic        cart_present;
    logic [13:0] cart_mask;
    logic        overflow;
    logic        hold_reset;

    always #5 clk = ~clk;

    cart_load_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_data     (ioctl_data),
        .ioctl_index    (ioctl_index),
        .cpu_req        (cpu_req),
        .cpu_addr       (cpu_addr),
        .cpu_data       (cpu_data),
        .cpu_ack        (cpu_ack),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_we         (mem_we),
        .mem_rdata      (mem_rdata),
        .cart_present   (cart_present),
        .cart_mask      (cart_mask),
        .overflow       (overflow),
        .hold_reset     (hold_reset)
    );

    // Cartridge RAM: registered read, write-enable from the DUT.
    logic [7:0] ram [BYTES];
    int         we_cnt = 0;
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            we_cnt        <= we_cnt + 1;
        end
        mem_rdata <= ram[mem_addr];
    end

    // Request history: an ack is owed two cycles after each request.
    logic r1, r2;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            r1 <= 1'b0;
            r2 <= 1'b0;
        end else begin
            r1 <= cpu_req;
            r2 <= r1;
        end
    end

    // Behavioural model of the loaded image.
    logic [7:0] mdl_img [BYTES];
    int         mdl_mask    = 0;
    bit         mdl_present = 1'b0;
    bit         mdl_run     = 1'b0;
    logic [7:0] exp_q [$];

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int mdl_mask_of(input int sz);
        int p;
        p = 1;
        if (sz == 0) return 0;
        while (p < sz) p = p * 2;
        if (p > BYTES) p = BYTES;
        return p - 1;
    endfunction

    function automatic logic [7:0] pat_byte(input int a, input int pat);
        logic [15:0] aa;
        logic [7:0]  t;
        aa = 16'(a);
        t  = 8'(a * 3);
        case (pat)
            1:       return aa[7:0] ^ 8'h3C;
            2:       return aa[7:0] ^ aa[15:8];
            3:       return t ^ 8'h5A;
            default: return aa[7:0];
        endcase
    endfunction

    function automatic logic [7:0] mdl_read(input logic [13:0] a);
        int idx;
        idx = int'(a) & mdl_mask;
        return (mdl_run && mdl_present) ? mdl_img[idx] : 8'hFF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_push(input logic [13:0] a, input logic [7:0] e);
        cpu_addr = a;
        cpu_req  = 1'b1;
        exp_q.push_back(e);
        tick();
        cpu_req  = 1'b0;
    endtask

    task automatic read(input logic [13:0] a);
        read_push(a, mdl_read(a));
    endtask

    task automatic read_lit(input string name, input logic [13:0] a, input logic [7:0] e);
        read(a);
        @(negedge clk);
        @(negedge clk);
        check({name, "_ack"}, cpu_ack, 1);
        check(name, cpu_data, e);
        tick();
    endtask

    task automatic read_seq(input int n, input int seed);
        for (int i = 0; i < n; i++) begin
            cpu_addr = 14'((seed * 977 + i * 1231) & 16'h3FFF);
            cpu_req  = 1'b1;
            exp_q.push_back(mdl_read(cpu_addr));
            tick();
        end
        cpu_req = 1'b0;
        repeat (3) tick();
    endtask

    task automatic load_file(input int n, input int pat, input logic [7:0] idx);
        int sz;
        int fend;
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        tick();
        tick();
        for (int a = 0; a < n; a++) begin
            ioctl_addr = 16'(a);
            ioctl_data = pat_byte(a, pat);
            ioctl_wr   = 1'b1;
            if (idx == CART_IDX && a < BYTES) mdl_img[a] = ioctl_data;
            tick();
        end
        ioctl_wr = 1'b0;
        tick();
        ioctl_download = 1'b0;
        if (idx == CART_IDX) begin
            sz          = (n > BYTES) ? BYTES : n;
            mdl_mask    = mdl_mask_of(sz);
            mdl_present = (sz != 0);
            mdl_run     = 1'b0;
            fend        = (sz == 0) ? BYTES - 1 : mdl_mask;
`ifdef CART_FILL_EN
            for (int a = sz; a <= fend; a++) mdl_img[a] = 8'hFF;
`endif
        end
        $display("load index=%0d bytes=%0d", idx, n);
    endtask

    task automatic wait_run();
        for (int i = 0; i < 40000; i++) begin
            @(negedge clk);
            if (!hold_reset) break;
        end
        check("hold_drop", hold_reset, 0);
        mdl_run = 1'b1;
        tick();
    endtask

    task automatic compare_loop();
        logic [7:0] e;
        forever begin
            @(negedge clk);
            check("ack_timing", cpu_ack, r2);
            if (cpu_ack && r2) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
                check("read_data", cpu_data, e);
                $display("read ack data=%h expected=%h", cpu_data, e);
            end
        end
    endtask

    int   w0;
    int   hcnt;
    int   fill_exp;

    initial begin
        for (int i = 0; i < BYTES; i++) begin
            mdl_img[i] = 8'h00;
            ram[i]     = 8'h00;
        end
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_data     = '0;
        ioctl_index    = '0;
        cpu_req        = 1'b0;
        cpu_addr       = '0;
        #1;
        check("rst_hold", hold_reset, 1);
        check("rst_data", cpu_data, 8'hFF);
        check("rst_flags", {cpu_ack, mem_we, cart_present, overflow}, 0);
        check("rst_mask", cart_mask, 0);
        check("rst_mem", {mem_addr, mem_wdata}, 0);
        fork
            compare_loop();
        join_none
        repeat (3) tick();
        reset = 1'b0;

        // Reads during the start-up hold and with no cartridge return FF.
        read_seq(2, 1);
        wait_run();
        read_lit("nocart_rd", 14'h0010, 8'hFF);

        // 8192-byte image: mask, present and the hold window length.
        w0 = we_cnt;
        load_file(8192, 0, CART_IDX);
        @(posedge clk);
        hcnt = 0;
        for (int i = 0; i < 40000; i++) begin
            @(negedge clk);
            if (!hold_reset) break;
            hcnt++;
        end
        mdl_run = 1'b1;
        check("hold_len", hcnt, HOLD + 1);
        check("we_8k", we_cnt - w0, 8192);
        check("mask_8k", cart_mask, 14'h1FFF);
        check("present_8k", cart_present, 1);
        check("ovf_8k", overflow, 0);
        tick();
        read_lit("mirror_rd", 14'h2005, 8'h05);
        read_seq(8, 7);

        // Read in flight when a new download starts, then a 5000-byte image.
        w0 = we_cnt;
        read_push(14'h0042, 8'hFF);
        load_file(5000, 1, CART_IDX);
        wait_run();
`ifdef CART_FILL_EN
        fill_exp = 8192;
        read_lit("pad_rd", 14'h1400, 8'hFF);
`else
        fill_exp = 5000;
        read_lit("stale_rd", 14'h1400, 8'h00);
`endif
        check("we_5k", we_cnt - w0, fill_exp);
        check("mask_5k", cart_mask, 14'h1FFF);
        read_lit("last_rd", 14'h1387, 8'hBB);
        read_seq(6, 3);

        // Oversized file.
        w0 = we_cnt;
        load_file(20000, 2, CART_IDX);
        wait_run();
        check("we_ovf", we_cnt - w0, BYTES);
        check("ovf_flag", overflow, 1);
        check("mask_ovf", cart_mask, 14'h3FFF);
        read_lit("ovf_rd0", 14'h0000, 8'h00);
        read_seq(6, 11);

        // Foreign index is ignored entirely.
        w0 = we_cnt;
        load_file(50, 1, 8'd0);
        repeat (3) tick();
        check("idx0_we", we_cnt - w0, 0);
        check("idx0_hold", hold_reset, 0);
        check("idx0_present", cart_present, 1);
        read_lit("idx0_rd", 14'h0000, 8'h00);

        // Empty cartridge download.
        load_file(0, 0, CART_IDX);
        wait_run();
        check("empty_present", cart_present, 0);
        check("empty_mask", cart_mask, 0);
        read_lit("empty_rd", 14'h0005, 8'hFF);

        // Reset in the middle of a load, then a fresh small image.
        ioctl_index    = CART_IDX;
        ioctl_download = 1'b1;
        tick();
        tick();
        for (int a = 0; a < 100; a++) begin
            ioctl_addr = 16'(a);
            ioctl_data = pat_byte(a, 0);
            ioctl_wr   = 1'b1;
            mdl_img[a] = ioctl_data;
            tick();
        end
        reset          = 1'b1;
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        mdl_present    = 1'b0;
        mdl_run        = 1'b0;
        mdl_mask       = 0;
        #1;
        check("midrst_present", cart_present, 0);
        check("midrst_hold", hold_reset, 1);
        repeat (2) tick();
        reset = 1'b0;
        wait_run();
        read_lit("midrst_rd", 14'h0003, 8'hFF);
        load_file(300, 3, CART_IDX);
        wait_run();
        check("mask_300", cart_mask, 14'h01FF);
        check("present_300", cart_present, 1);
        read_lit("fresh_rd", 14'h1234, 8'hC6);
        read_seq(5, 5);

        repeat (4) tick();
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
